// File: rtl/cdb_arbiter_pkg.sv
// Shared CPU parameters: common data bus sizing and the CDB data
// controller's constants.
package cdb_arbiter_pkg;

  // Functional units competing for the common data bus
  localparam int FU_NUM    = 6;
  // Broadcast slots on the bus each cycle
  localparam int CDB_PORTS = 2;
  // Result width
  localparam int WORD_SIZE = 32;
  // Reorder-buffer tag width
  localparam int RB_INDEX  = 4;
  // Tag value that marks "no destination"; never broadcast
  localparam logic [RB_INDEX-1:0] NULL = '1;

  // CDB data controller constants
  localparam int CDB_CTRL_LATENCY = 1;  // grant-to-broadcast delay in cycles
  localparam int CDB_CTRL_DEPTH   = 2;  // consumer-side skid buffer entries

endpackage : cdb_arbiter_pkg

// File: rtl/cdb_rr_picker.sv
// Combinational multi-grant round-robin picker. Starting at ptr it scans the
// eligible vector upward modulo FU_NUM and hands out up to CDB_PORTS grants,
// filling slots in scan order.
module cdb_rr_picker #(
  parameter  int FU_NUM    = cdb_arbiter_pkg::FU_NUM,
  parameter  int CDB_PORTS = cdb_arbiter_pkg::CDB_PORTS,
  localparam int PTR_W     = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic [FU_NUM-1:0]                eligible,
  input  logic [PTR_W-1:0]                 ptr,
  output logic [FU_NUM-1:0]                grant,
  output logic [CDB_PORTS-1:0]             slot_used,
  output logic [CDB_PORTS-1:0][PTR_W-1:0]  slot_fu,
  output logic [PTR_W-1:0]                 next_ptr
);

  // Walk the FUs once from ptr; the k-th hit takes slot k, the last hit moves ptr
  always_comb begin
    int cnt;
    int idx;
    // NOTE: every output gets a default before the loop, otherwise the
    // conditional assignments below would infer latches.
    grant     = '0;
    slot_used = '0;
    slot_fu   = '0;
    next_ptr  = ptr;
    cnt       = 0;
    idx       = 0;
    for (int off = 0; off < FU_NUM; off++) begin
      idx = int'(ptr) + off;
      if (idx >= FU_NUM) idx = idx - FU_NUM;
      if (eligible[idx] && (cnt < CDB_PORTS)) begin
        grant[idx]     = 1'b1;
        slot_used[cnt] = 1'b1;
        slot_fu[cnt]   = PTR_W'(idx);
        next_ptr       = (idx == FU_NUM - 1) ? '0 : PTR_W'(idx + 1);
        cnt            = cnt + 1;
      end
    end
  end

endmodule : cdb_rr_picker

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks up to CDB_PORTS ready functional units per
// cycle in round-robin order and broadcasts their results one cycle later.
module cdb_arbiter #(
  parameter  int                  FU_NUM    = cdb_arbiter_pkg::FU_NUM,
  parameter  int                  CDB_PORTS = cdb_arbiter_pkg::CDB_PORTS,
  parameter  int                  WORD_SIZE = cdb_arbiter_pkg::WORD_SIZE,
  parameter  int                  RB_INDEX  = cdb_arbiter_pkg::RB_INDEX,
  parameter  logic [RB_INDEX-1:0] NULL      = '1,
  localparam int                  PTR_W     = (FU_NUM > 1) ? $clog2(FU_NUM) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            stall,
  input  logic [FU_NUM-1:0]               req,
  input  logic [FU_NUM*WORD_SIZE-1:0]     fu_data,
  input  logic [FU_NUM*RB_INDEX-1:0]      fu_rb_index,
  output logic [FU_NUM-1:0]               grant,
  output logic [CDB_PORTS-1:0]            cdb_valid,
  output logic [CDB_PORTS*WORD_SIZE-1:0]  cdb_data,
  output logic [CDB_PORTS*RB_INDEX-1:0]   cdb_rb_index
);

  logic [PTR_W-1:0]                ptr;
  logic [PTR_W-1:0]                next_ptr;
  logic [FU_NUM-1:0]               eligible;
  logic [CDB_PORTS-1:0]            slot_used;
  logic [CDB_PORTS-1:0][PTR_W-1:0] slot_fu;

  // An FU may compete only with a real destination tag on a free, live bus
  always_comb begin
    eligible = '0;
    for (int i = 0; i < FU_NUM; i++) begin
      eligible[i] = req[i] && (fu_rb_index[i*RB_INDEX +: RB_INDEX] != NULL)
                    && !stall && !flush && !reset;
    end
  end

  cdb_rr_picker #(
    .FU_NUM    (FU_NUM),
    .CDB_PORTS (CDB_PORTS)
  ) u_picker (
    .eligible  (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .slot_used (slot_used),
    .slot_fu   (slot_fu),
    .next_ptr  (next_ptr)
  );

  // Slot registers and round-robin pointer: reset/flush clear, stall holds,
  // otherwise capture the granted FUs into their slots
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the slot registers are a handful of flops, not a RAM, so they
      // are reset explicitly; in-flight grants are dropped here.
      ptr          <= '0;
      cdb_valid    <= '0;
      cdb_data     <= '0;
      cdb_rb_index <= {CDB_PORTS{NULL}};
    end else if (flush) begin
      cdb_valid    <= '0;
      cdb_data     <= '0;
      cdb_rb_index <= {CDB_PORTS{NULL}};
    end else if (!stall) begin
      for (int s = 0; s < CDB_PORTS; s++) begin
        if (slot_used[s]) begin
          cdb_valid[s]                           <= 1'b1;
          cdb_data[s*WORD_SIZE +: WORD_SIZE]     <=
            fu_data[int'(slot_fu[s])*WORD_SIZE +: WORD_SIZE];
          cdb_rb_index[s*RB_INDEX +: RB_INDEX]   <=
            fu_rb_index[int'(slot_fu[s])*RB_INDEX +: RB_INDEX];
        end else begin
          cdb_valid[s]                           <= 1'b0;
          cdb_data[s*WORD_SIZE +: WORD_SIZE]     <= '0;
          cdb_rb_index[s*RB_INDEX +: RB_INDEX]   <= NULL;
        end
      end
      ptr <= next_ptr;
    end
  end

endmodule : cdb_arbiter

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int FU_NUM    = 6;
  localparam int CDB_PORTS = 2;
  localparam int WORD_SIZE = 32;
  localparam int RB_INDEX  = 4;

  logic                           clk;
  logic                           reset;
  logic                           flush;
  logic                           stall;
  logic [FU_NUM-1:0]              req;
  logic [FU_NUM*WORD_SIZE-1:0]    fu_data;
  logic [FU_NUM*RB_INDEX-1:0]     fu_rb_index;
  logic [FU_NUM-1:0]              grant;
  logic [CDB_PORTS-1:0]           cdb_valid;
  logic [CDB_PORTS*WORD_SIZE-1:0] cdb_data;
  logic [CDB_PORTS*RB_INDEX-1:0]  cdb_rb_index;

  int tests_run = 0;
  int tests_failed = 0;

  cdb_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .stall        (stall),
    .req          (req),
    .fu_data      (fu_data),
    .fu_rb_index  (fu_rb_index),
    .grant        (grant),
    .cdb_valid    (cdb_valid),
    .cdb_data     (cdb_data),
    .cdb_rb_index (cdb_rb_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default operands: FU i carries data 0x100+i and tag i+1
  task automatic load_defaults();
    for (int i = 0; i < FU_NUM; i++) begin
      fu_data[i*WORD_SIZE +: WORD_SIZE]  = 32'h100 + 32'(i);
      fu_rb_index[i*RB_INDEX +: RB_INDEX] = 4'(i + 1);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; req = '0;
    fu_data = '0; fu_rb_index = '0;
    load_defaults();

    // Reset: grant suppressed, slots cleared
    tick();
    req = 6'b111111; #1;
    check("reset_grant", 64'(grant), 64'h0);
    tick();
    check("reset_valid", 64'(cdb_valid), 64'h0);
    check("reset_tags", 64'(cdb_rb_index), 64'hFF);
    check("reset_data", 64'(cdb_data), 64'h0);

    // Idle after reset
    reset = 1'b0; req = '0; #1;
    check("idle_grant", 64'(grant), 64'h0);
    tick();
    check("idle_valid", 64'(cdb_valid), 64'h0);
    check("idle_tags", 64'(cdb_rb_index), 64'hFF);

    // Round-robin: all FUs request, ptr starts at 0
    req = 6'b111111; #1;
    check("rr1_grant", 64'(grant), 64'h03);
    tick();
    check("rr1_valid", 64'(cdb_valid), 64'h3);
    check("rr1_tags", 64'(cdb_rb_index), 64'h21);
    check("rr1_data", 64'(cdb_data), 64'h00000101_00000100);
    #1;
    check("rr2_grant", 64'(grant), 64'h0C);
    tick();
    check("rr2_tags", 64'(cdb_rb_index), 64'h43);
    #1;
    check("rr3_grant", 64'(grant), 64'h30);
    tick();
    check("rr3_tags", 64'(cdb_rb_index), 64'h65);
    check("rr3_data", 64'(cdb_data), 64'h00000105_00000104);

    // Move ptr to 5 with a lone FU4 grant, slot 1 left unused
    req = 6'b010000; #1;
    check("solo4_grant", 64'(grant), 64'h10);
    tick();
    check("solo4_valid", 64'(cdb_valid), 64'h1);
    check("solo4_tags", 64'(cdb_rb_index), 64'hF5);
    check("solo4_data", 64'(cdb_data), 64'h00000000_00000104);

    // Wrap-around from ptr=5: FU5 slot 0, FU0 slot 1, next ptr=1
    req = 6'b100001; #1;
    check("wrap_grant", 64'(grant), 64'h21);
    tick();
    check("wrap_valid", 64'(cdb_valid), 64'h3);
    check("wrap_tags", 64'(cdb_rb_index), 64'h16);
    // ptr=1 means FU1 is scanned before FU0
    req = 6'b000011; #1;
    check("ptr1_grant", 64'(grant), 64'h03);
    tick();
    check("ptr1_tags", 64'(cdb_rb_index), 64'h12);

    // Stall then flush: ptr=1, grant FU2 with data DEAD tag 3
    fu_data[2*WORD_SIZE +: WORD_SIZE] = 32'hDEAD;
    req = 6'b000100; #1;
    check("dead_grant", 64'(grant), 64'h04);
    tick();
    check("dead_tags", 64'(cdb_rb_index), 64'hF3);
    check("dead_data", 64'(cdb_data), 64'h00000000_0000DEAD);
    stall = 1'b1; req = 6'b111111; #1;
    for (int c = 0; c < 2; c++) begin
      check("stall_grant", 64'(grant), 64'h0);
      tick();
      check("stall_valid", 64'(cdb_valid), 64'h1);
      check("stall_tags", 64'(cdb_rb_index), 64'hF3);
      check("stall_data", 64'(cdb_data), 64'h00000000_0000DEAD);
    end
    flush = 1'b1; #1;
    check("flush_grant", 64'(grant), 64'h0);
    tick();
    check("flush_valid", 64'(cdb_valid), 64'h0);
    check("flush_tags", 64'(cdb_rb_index), 64'hFF);
    flush = 1'b0; stall = 1'b0;
    load_defaults();

    // NULL tag on FU1 with ptr=3: only FU2 granted on slot 0
    fu_rb_index[1*RB_INDEX +: RB_INDEX] = 4'hF;
    req = 6'b000110; #1;
    check("null_grant", 64'(grant), 64'h04);
    tick();
    check("null_valid", 64'(cdb_valid), 64'h1);
    check("null_tags", 64'(cdb_rb_index), 64'hF3);
    // ptr stays 3, so FU1 still precedes FU2 once its tag is valid
    load_defaults(); #1;
    check("null_ptr_grant", 64'(grant), 64'h06);
    tick();
    check("null_ptr_tags", 64'(cdb_rb_index), 64'h32);

    // Reset mid-operation: in-flight grant dropped, ptr back to 0
    req = 6'b111111; #1;
    check("pre_reset_grant", 64'(grant), 64'h18);
    reset = 1'b1; #1;
    check("midreset_grant", 64'(grant), 64'h0);
    tick();
    check("midreset_valid", 64'(cdb_valid), 64'h0);
    check("midreset_tags", 64'(cdb_rb_index), 64'hFF);
    reset = 1'b0; #1;
    check("post_reset_grant", 64'(grant), 64'h03);
    tick();
    check("post_reset_tags", 64'(cdb_rb_index), 64'h21);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_cdb_arbiter
